clk_period_meter: RTL and testbench

//   Measures a slow clock-like input (e.g. the output of clk_div) in cycles of the system clock.

---
 rtl/clk_period_meter_pkg.sv | 12 +
 rtl/clk_period_meter_sync_edge_det.sv | 32 +++
 rtl/clk_period_meter.sv | 126 ++++++++++++
 tb/tb_clk_period_meter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for clk_period_meter: FSM state encoding and default counter width.
`timescale 1ns/1ps
package clk_period_meter_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous input plus a one-flop
// delayed copy used to derive single-cycle rise/fall strobes in the clk domain.
`timescale 1ns/1ps
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d_async};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q_sync = chain[STAGES-1];
    assign rise   = q_sync & ~q_d;
    assign fall   = ~q_sync & q_d;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: counts clk cycles between rising edges of an asynchronous input.
// Define CLK_METER_DUTY_EN to also measure the high time within each period.
`timescale 1ns/1ps
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             ovf,
    output logic             valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall_unused;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             report;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (sig_in),
        .q_sync  (s),
        .rise    (rise),
        .fall    (fall_unused)
    );

    // The first rise after IDLE only starts timing; later rises close a period and restart at 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        report     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (en && rise) begin
                    state_next = ST_MEASURE;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!en) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (rise) begin
                    report   = 1'b1;
                    cnt_next = CNT_ONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            period <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            valid <= report;
            if (report) begin
                period <= cnt;
                ovf    <= (cnt == CNT_MAX);
            end
        end
    end

`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_cnt_next;
    logic [CNT_W-1:0] hi_total;

    // The rise cycle itself counts as high, so the reported value is hi_cnt plus s.
    assign hi_total = (hi_cnt == CNT_MAX) ? CNT_MAX : hi_cnt + CNT_W'(s);

    always_comb begin
        hi_cnt_next = hi_cnt;
        if (state != ST_MEASURE || !en || rise) begin
            hi_cnt_next = '0;
        end else if (s && hi_cnt != CNT_MAX) begin
            hi_cnt_next = hi_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt    <= '0;
            high_time <= '0;
        end else begin
            hi_cnt <= hi_cnt_next;
            if (report) begin
                high_time <= hi_total;
            end
        end
    end
`else
    logic s_unused;
    assign s_unused  = s;
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed scenarios plus random high/low
// segments, checked against a segment-level model of expected reports.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         ovf;
    logic         valid;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    logic [W-1:0] last_period = '0;
    logic [W-1:0] last_high   = '0;
    logic         last_ovf    = 1'b0;
    bit   armed  = 0;
    int   prev_h = 0;
    int   prev_l = 0;

    clk_period_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .ovf       (ovf),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    function automatic logic [W-1:0] sat(input int v);
        return (v >= MAX) ? W'(MAX) : W'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One high/low segment of sig_in; its rise closes the previous segment's period.
    task automatic applyStimulus(input int h, input int l);
        exp_t e;
        if (armed) begin
            e.period = sat(prev_h + prev_l);
`ifdef CLK_METER_DUTY_EN
            e.high = sat(prev_h);
`else
            e.high = '0;
`endif
            e.ovf = ((prev_h + prev_l) >= MAX);
            exp_q.push_back(e);
        end
        armed  = 1;
        prev_h = h;
        prev_l = l;
        @(negedge clk) sig_in = 1'b1;
        repeat (h - 1) @(negedge clk);
        @(negedge clk) sig_in = 1'b0;
        repeat (l - 1) @(negedge clk);
    endtask

    // Every valid must match the next modelled report; otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            checkOutput("valid_has_pending_report", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("period", 32'(period), 32'(e.period));
                checkOutput("high_time", 32'(high_time), 32'(e.high));
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
                last_period = e.period;
                last_high   = e.high;
                last_ovf    = e.ovf;
            end
        end else begin
            checkOutput("hold_period", 32'(period), 32'(last_period));
            checkOutput("hold_high_time", 32'(high_time), 32'(last_high));
            checkOutput("hold_ovf", 32'(ovf), 32'(last_ovf));
        end
    end

    initial begin
        int h;
        int l;
        rst_n  = 1'b0;
        en     = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_period", 32'(period), 32'd0);
        checkOutput("reset_high_time", 32'(high_time), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] divide-by-4 input");
        repeat (8) applyStimulus(2, 2);

        $display("[TB] high 3 / low 7");
        repeat (4) applyStimulus(3, 7);

        $display("[TB] saturation and re-arm");
        applyStimulus(5, 300);
        applyStimulus(5, 250);
        applyStimulus(2, 4);
        applyStimulus(3, 3);

        $display("[TB] enable dropped mid-period");
        applyStimulus(3, 20);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en    = 1'b1;
        armed = 0;
        repeat (4) @(negedge clk);
        applyStimulus(2, 5);
        applyStimulus(2, 5);
        applyStimulus(3, 4);

        $display("[TB] rise coincident with enable falling");
        armed = 0;
        @(negedge clk) sig_in = 1'b1;
        @(negedge clk);
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        @(negedge clk) sig_in = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(2, 3);
        applyStimulus(2, 3);
        applyStimulus(4, 12);

        $display("[TB] asynchronous reset mid-period");
        #0.5 rst_n = 1'b0;
        #0.2;
        checkOutput("midreset_period", 32'(period), 32'd0);
        checkOutput("midreset_high_time", 32'(high_time), 32'd0);
        checkOutput("midreset_ovf", 32'(ovf), 32'd0);
        checkOutput("midreset_valid", 32'(valid), 32'd0);
        exp_q.delete();
        last_period = '0;
        last_high   = '0;
        last_ovf    = 1'b0;
        armed       = 0;
        repeat (2) @(negedge clk);
        #0.3 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] minimum period of 2");
        repeat (10) applyStimulus(1, 1);

        $display("[TB] random segments");
        repeat (40) begin
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            applyStimulus(h, l);
        end
        applyStimulus(1, 4);

        repeat (20) @(negedge clk);
        checkOutput("report_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
